c_ex_muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage, fed by the ID/EX control register (`ExPathE`, `funct3_E`, `FlushE`) and the EX operand muxes. It runs one radix-2 step per cycle for MUL/DIV/REM operations. While busy it raises `MulDivStallE`, which the hazard unit ORs into the F/D/E stall lines. When finished it presents a 32-bit result on `MulDivResultE` for the EX result mux.

---
 rtl/c_ex_muldiv_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/c_ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One radix-2 step per cycle; divide-by-zero and signed overflow finish in one cycle.
module c_ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MulDivStartE,
  input  logic [2:0]  funct3_E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  input  logic        StallExtE,
  output logic        MulDivStallE,
  output logic        MulDivDoneE,
  output logic [31:0] MulDivResultE
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [2:0]        op, op_n;
  logic              neg, neg_n;
  logic [2*XLEN-1:0] acc, acc_n;
  logic [XLEN-1:0]   opb, opb_n;
  logic [XLEN-1:0]   result_n;
  logic              done_n;

  // Operand decode for the start cycle
  logic            a_signed, b_signed, a_neg, b_neg, neg_start;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign a_signed  = (funct3_E == 3'b001) || (funct3_E == 3'b010) ||
                     (funct3_E == 3'b100) || (funct3_E == 3'b110);
  assign b_signed  = (funct3_E == 3'b001) || (funct3_E == 3'b100) || (funct3_E == 3'b110);
  assign a_neg     = a_signed & SrcAE[XLEN-1];
  assign b_neg     = b_signed & SrcBE[XLEN-1];
  assign mag_a     = a_neg ? (~SrcAE + 32'd1) : SrcAE;
  assign mag_b     = b_neg ? (~SrcBE + 32'd1) : SrcBE;
  // Remainder follows the dividend; products and quotients follow sign(A) xor sign(B)
  assign neg_start = (funct3_E[2] & funct3_E[1]) ? a_neg : (a_neg ^ b_neg);
  assign div_zero  = funct3_E[2] && (SrcBE == 32'd0);
  assign div_ovf   = funct3_E[2] && !funct3_E[0] &&
                     (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
  assign special_res = div_zero ? (funct3_E[1] ? SrcAE : 32'hFFFF_FFFF)
                                : (funct3_E[1] ? 32'd0 : 32'h8000_0000);

  // Multiply step: acc = {partial product, remaining multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_acc = {mul_sum, acc[XLEN-1:1]};

  // Divide step: acc = {partial remainder, dividend/quotient bits}
  logic [XLEN:0]     rem_sh, trial;
  logic [2*XLEN-1:0] div_acc;
  assign rem_sh  = acc[2*XLEN-1:XLEN-1];
  assign trial   = rem_sh - {1'b0, opb};
  assign div_acc = trial[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] step_acc, prod;
  logic [XLEN-1:0]   quo, rem, final_res;
  assign step_acc = op[2] ? div_acc : mul_acc;
  assign prod     = neg ? (~step_acc + 64'd1) : step_acc;
  assign quo      = step_acc[XLEN-1:0];
  assign rem      = step_acc[2*XLEN-1:XLEN];

  always_comb begin
    final_res = 32'd0;
    case (op)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = neg ? (~quo + 32'd1) : quo;
      default:                final_res = neg ? (~rem + 32'd1) : rem;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      op            <= '0;
      neg           <= 1'b0;
      acc           <= '0;
      opb           <= '0;
      MulDivResultE <= '0;
      MulDivDoneE   <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      op            <= op_n;
      neg           <= neg_n;
      acc           <= acc_n;
      opb           <= opb_n;
      MulDivResultE <= result_n;
      MulDivDoneE   <= done_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n  = state;
    count_n  = count;
    op_n     = op;
    neg_n    = neg;
    acc_n    = acc;
    opb_n    = opb;
    result_n = MulDivResultE;
    done_n   = 1'b0;
    if (FlushE) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (MulDivStartE) begin
            op_n    = funct3_E;
            neg_n   = neg_start;
            opb_n   = mag_b;
            acc_n   = {32'd0, mag_a};
            count_n = '0;
            if (div_zero || div_ovf) begin
              result_n = special_res;
              state_n  = DONE;
              done_n   = 1'b1;
            end else begin
              state_n = CALC;
            end
          end
        end
        CALC: begin
          acc_n   = step_acc;
          count_n = count + 5'd1;
          if (count == 5'd31) begin
            result_n = final_res;
            state_n  = DONE;
            done_n   = 1'b1;
          end
        end
        DONE: begin
          if (StallExtE) done_n = 1'b1;
          else           state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign MulDivStallE = !FlushE && (((state == IDLE) && MulDivStartE) || (state == CALC));

endmodule
